// File: rtl/cpu_fetch_queue_pkg.sv
// Shared fetch/decode types for the decode-side fetch queue.
package cpu_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_data_t;

    localparam int FETCH_DATA_W = $bits(fetch_data_t);

endpackage

// File: rtl/cpu_fetch_queue_if.sv
// Fetch-to-decode link: fetch output/stall on one side, decode valid/ready stream on the other.
interface cpu_fetch_queue_if #(
    parameter int DEPTH_LOG2 = 2
);
    import cpu_fetch_queue_pkg::*;

    // Decode stream: an entry transfers on any cycle where o_valid && i_ready;
    // o_data holds the head and stays stable while o_valid && !i_ready.
    fetch_data_t           i_data;
    logic                  o_busy;
    logic                  i_flush;
    logic                  o_valid;
    fetch_data_t           o_data;
    logic                  i_ready;
    logic [DEPTH_LOG2:0]   o_count;

    modport slave (
        input  i_data, i_flush, i_ready,
        output o_busy, o_valid, o_data, o_count
    );

    modport master (
        output i_data, i_flush, i_ready,
        input  o_busy, o_valid, o_data, o_count
    );

endinterface

// File: rtl/cpu_fetch_queue_mem.sv
// Register-array storage for the fetch queue: one write port, one asynchronous read port.
module cpu_fetch_queue_mem
    import cpu_fetch_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clock,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  fetch_data_t           wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output fetch_data_t           rd_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    fetch_data_t mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_fetch_queue.sv
// Decode-side fetch receiver: detects new instructions by tag change and buffers them
// in a small FWFT FIFO, back-pressuring fetch early enough that nothing is lost.
module cpu_fetch_queue
    import cpu_fetch_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    cpu_fetch_queue_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C    = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] BUSY_LEVEL = DEPTH_C - 1'b1;

    logic [31:0]           last_tag;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  valid;
    logic                  wr_en;
    fetch_data_t           rd_data;

    assign push  = (bus.i_data.tag != last_tag);
    assign full  = (count == DEPTH_C);
    assign valid = (count != '0);
    assign pop   = valid && bus.i_ready;
    assign wr_en = push && !full && !bus.i_flush;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_tag <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.i_flush) begin
            // Adopting the visible tag discards the entry fetch is currently presenting.
            last_tag <= bus.i_data.tag;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                last_tag <= bus.i_data.tag;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    cpu_fetch_queue_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .i_clock (i_clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Busy one entry early: fetch may still land one capture after seeing it.
    assign bus.o_busy  = (count >= BUSY_LEVEL);
    assign bus.o_valid = valid;
    assign bus.o_data  = valid ? rd_data : '0;
    assign bus.o_count = count;

    no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
        !(push && full && !bus.i_flush));

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Randomized bench for cpu_fetch_queue against a queue-based reference model.
module tb_cpu_fetch_queue;
    import cpu_fetch_queue_pkg::*;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic i_clock = 1'b0;
    logic i_reset;

    always #5 i_clock = ~i_clock;

    cpu_fetch_queue_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    cpu_fetch_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    logic [FETCH_DATA_W-1:0] exp_q [$];
    logic [31:0]             pop_log [$];
    logic [31:0]             m_last_tag;
    logic                    last_busy;
    int                      max_count;
    int unsigned             next_tag;
    logic [31:0]             next_pc;
    int                      n_checks;
    int                      n_fail;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fetch_new();
        bus.i_data = '{tag: next_tag, instruction: $urandom, pc: next_pc};
        next_tag++;
        next_pc += 32'd4;
    endtask

    task automatic check_outputs();
        fetch_data_t exp_head;
        exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_eq("count", bus.o_count, exp_q.size());
        check_eq("valid", bus.o_valid, exp_q.size() != 0);
        check_eq("data",  bus.o_data,  exp_head);
        check_eq("busy",  bus.o_busy,  exp_q.size() >= DEPTH - 1);
        last_busy = bus.o_busy;
        if (int'(bus.o_count) > max_count) max_count = int'(bus.o_count);
    endtask

    // Reference behaviour for one clock edge, using the inputs the DUT samples.
    task automatic model_update();
        bit do_pop;
        bit do_push;
        fetch_data_t head;
        if (i_reset) begin
            exp_q.delete();
            m_last_tag = '0;
        end else if (bus.i_flush) begin
            exp_q.delete();
            m_last_tag = bus.i_data.tag;
        end else begin
            do_pop  = (exp_q.size() != 0) && bus.i_ready;
            do_push = (bus.i_data.tag != m_last_tag);
            if (do_push) check_eq("no_overflow", exp_q.size() == DEPTH, 1'b0);
            if (do_pop) begin
                head = exp_q.pop_front();
                pop_log.push_back(head.pc);
            end
            if (do_push) begin
                if (exp_q.size() + (do_pop ? 1 : 0) < DEPTH) exp_q.push_back(bus.i_data);
                m_last_tag = bus.i_data.tag;
            end
        end
    endtask

    task automatic cycle();
        @(negedge i_clock);
        check_outputs();
        @(posedge i_clock);
        model_update();
        #1;
    endtask

    task automatic drain();
        bus.i_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
    endtask

    initial begin
        int base_cnt;
        n_checks  = 0;
        n_fail    = 0;
        max_count = 0;
        next_tag  = 1;
        next_pc   = '0;
        last_busy = 1'b0;
        i_reset     = 1'b1;
        bus.i_data  = '0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b0;
        exp_q.delete();
        m_last_tag = '0;
        @(posedge i_clock);
        #1;
        cycle();
        i_reset = 1'b0;
        cycle();
        check_eq("reset_valid", bus.o_valid, 1'b0);
        check_eq("reset_busy",  bus.o_busy,  1'b0);

        // Three back-to-back tags, decode always ready.
        bus.i_ready = 1'b1;
        pop_log.delete();
        for (int i = 0; i < 3; i++) begin
            fetch_new();
            cycle();
        end
        for (int i = 0; i < 4; i++) cycle();
        check_eq("seq_pops", pop_log.size(), 3);
        for (int i = 0; i < 3 && i < pop_log.size(); i++)
            check_eq("seq_pc", pop_log[i], 32'(i * 4));

        // Fill with decode stalled; fetch honours busy with one capture of lag.
        bus.i_ready = 1'b0;
        max_count   = 0;
        base_cnt    = 6;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (!last_busy && base_cnt > 0) begin
                fetch_new();
                base_cnt--;
            end
        end
        check_eq("peak_count", max_count, DEPTH);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (!last_busy && base_cnt > 0) begin
                fetch_new();
                base_cnt--;
            end
        end
        check_eq("fill_drained", bus.o_count, 0);

        // Constant tag: no pushes.
        bus.i_ready = 1'b0;
        fetch_new();
        cycle();
        base_cnt = exp_q.size();
        for (int i = 0; i < 10; i++) cycle();
        check_eq("hold_count", bus.o_count, base_cnt);
        drain();

        // Tag wrap 0xFFFFFFFF -> 0 is one push.
        bus.i_ready = 1'b0;
        bus.i_data  = '{tag: 32'hFFFF_FFFF, instruction: $urandom, pc: next_pc};
        cycle();
        cycle();
        check_eq("wrap_first", bus.o_count, 1);
        bus.i_data  = '{tag: 32'h0, instruction: $urandom, pc: next_pc + 32'd4};
        for (int i = 0; i < 3; i++) cycle();
        check_eq("wrap_second", bus.o_count, 2);
        next_tag = 1;
        drain();

        // Flush with three entries stored and a new tag visible.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_new();
            cycle();
        end
        cycle();
        check_eq("pre_flush", bus.o_count, 3);
        fetch_new();
        bus.i_flush = 1'b1;
        cycle();
        bus.i_flush = 1'b0;
        check_eq("flush_count", bus.o_count, 0);
        check_eq("flush_valid", bus.o_valid, 1'b0);
        cycle();
        cycle();
        check_eq("flush_no_push", bus.o_count, 0);
        fetch_new();
        cycle();
        cycle();
        check_eq("post_flush_push", bus.o_count, 1);
        drain();

        // Random streaming: capture whenever allowed, random decode readiness.
        for (int i = 0; i < 100; i++) begin
            bus.i_ready = 1'($urandom_range(0, 1));
            cycle();
            if (!last_busy && $urandom_range(0, 3) != 0) fetch_new();
        end
        drain();

        // Reset with two entries stored.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fetch_new();
            cycle();
        end
        cycle();
        check_eq("pre_reset", bus.o_count, 2);
        i_reset    = 1'b1;
        bus.i_data = '0;
        cycle();
        i_reset  = 1'b0;
        next_tag = 1;
        next_pc  = '0;
        check_eq("rst_valid", bus.o_valid, 1'b0);
        check_eq("rst_count", bus.o_count, 0);
        check_eq("rst_data",  bus.o_data,  '0);
        check_eq("rst_busy",  bus.o_busy,  1'b0);
        for (int i = 0; i < 3; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
